// File: rtl/disp_pager.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pager
//  Description : Pages one of four 32-bit sources onto an 8-digit hex display.
//                It supports manual paging, timed auto-scan, and round-robin
//                request grants that pin a page for HOLD_CYC cycles. When the
//                pin expires, the previous page is restored.
//                Optional macro DISP_PAGER_TAG_EN puts 4'hA+page in the top
//                display nibble.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_pager #(
    parameter int HOLD_CYC = 100_000_000,
    parameter int SCAN_CYC = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] src_data,
    input  logic [3:0]   req,
    output logic [3:0]   ack,
    input  logic         btn_next,
    input  logic         auto_en,
    output logic [31:0]  disp_num,
    output logic [1:0]   page,
    output logic         pinned
);

    localparam int c_HOLD_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
    localparam int c_SCAN_W = (SCAN_CYC > 2) ? $clog2(SCAN_CYC) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYC - 1);
    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_CYC - 1);

    typedef enum logic [1:0] {
        ST_MAN  = 2'd0,
        ST_AUTO = 2'd1,
        ST_PIN  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_page;
    logic [1:0]            r_saved;
    logic [1:0]            r_rr;        // first index examined by the next search
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [c_SCAN_W-1:0]   r_scan_cnt;
    logic [3:0]            r_ack;
    logic [31:0]           r_disp;

    logic                  w_grant;
    logic [1:0]            w_gnt_idx;
    logic                  w_hold_done;
    logic [31:0]           w_word;
    logic [31:0]           w_disp;

    // Round-robin search over req, starting at the pointer and wrapping
    always_comb begin : p_rr_search
        logic       found;
        logic [1:0] idx;
        found     = 1'b0;
        idx       = r_rr;
        w_gnt_idx = r_rr;
        for (int k = 0; k < 4; k++) begin
            idx = r_rr + 2'(k);
            if (!found && req[idx]) begin
                found     = 1'b1;
                w_gnt_idx = idx;
            end
        end
    end

    assign w_grant     = (r_state != ST_PIN) && (|req);
    assign w_hold_done = (r_state == ST_PIN) && (r_hold_cnt == '0);

    // Next-state: a grant pins the page, a running hold stays pinned,
    // otherwise auto_en chooses between auto-scan and manual mode
    always_comb begin
        w_state_nxt = auto_en ? ST_AUTO : ST_MAN;
        if (w_grant) begin
            w_state_nxt = ST_PIN;
        end else if ((r_state == ST_PIN) && !w_hold_done) begin
            w_state_nxt = ST_PIN;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_MAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Display word selected by the current page register
    assign w_word = src_data[32*r_page +: 32];
`ifdef DISP_PAGER_TAG_EN
    assign w_disp = {4'hA + {2'b00, r_page}, w_word[27:0]};
`else
    assign w_disp = w_word;
`endif

    // Page, counters, grant pulse, and display register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_page     <= '0;
            r_saved    <= '0;
            r_rr       <= '0;
            r_hold_cnt <= '0;
            r_scan_cnt <= '0;
            r_ack      <= '0;
            r_disp     <= '0;
        end else begin
            r_ack  <= '0;
            r_disp <= w_disp;
            if (w_grant) begin
                // A grant takes precedence over btn_next, which is dropped
                r_ack      <= 4'd1 << w_gnt_idx;
                r_saved    <= r_page;
                r_page     <= w_gnt_idx;
                r_hold_cnt <= c_HOLD_LOAD;
                r_rr       <= w_gnt_idx + 2'd1;
            end else begin
                case (r_state)
                    ST_PIN: begin
                        if (w_hold_done) begin
                            r_page <= r_saved;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - 1'b1;
                        end
                    end
                    ST_AUTO: begin
                        if (btn_next || (r_scan_cnt == c_SCAN_LAST)) begin
                            r_page     <= r_page + 2'd1;
                            r_scan_cnt <= '0;
                        end else begin
                            r_scan_cnt <= r_scan_cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (btn_next) begin
                            r_page <= r_page + 2'd1;
                        end
                    end
                endcase
            end
            // Each entry into auto-scan begins a full scan interval
            if ((w_state_nxt == ST_AUTO) && (r_state != ST_AUTO)) begin
                r_scan_cnt <= '0;
            end
        end
    end

    assign ack      = r_ack;
    assign page     = r_page;
    assign pinned   = (r_state == ST_PIN);
    assign disp_num = r_disp;

endmodule
`default_nettype wire

// File: tb/tb_disp_pager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_pager
//  Description : Directed self-checking bench for disp_pager.
//                It uses HOLD_CYC=8 and SCAN_CYC=4. The expected display
//                value follows DISP_PAGER_TAG_EN when that macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_pager;

    logic         clk;
    logic         rst;
    logic [127:0] src_data;
    logic [3:0]   req;
    logic [3:0]   ack;
    logic         btn_next;
    logic         auto_en;
    logic [31:0]  disp_num;
    logic [1:0]   page;
    logic         pinned;

    int n_vec;
    int n_err;

    disp_pager #(
        .HOLD_CYC (8),
        .SCAN_CYC (4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .src_data (src_data),
        .req      (req),
        .ack      (ack),
        .btn_next (btn_next),
        .auto_en  (auto_en),
        .disp_num (disp_num),
        .page     (page),
        .pinned   (pinned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_disp(input logic [1:0] pg, input logic [31:0] word);
`ifdef DISP_PAGER_TAG_EN
        return {4'hA + {2'b00, pg}, word[27:0]};
`else
        return word;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        req      = 4'b0;
        btn_next = 1'b0;
        auto_en  = 1'b0;
        src_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

        // ---- Scenario 1: reset values and manual paging ----
        #3;
        chk("rst_page",   {30'b0, page},  32'd0);
        chk("rst_disp",   disp_num,       32'd0);
        chk("rst_ack",    {28'b0, ack},   32'd0);
        chk("rst_pinned", {31'b0, pinned}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("man_page0", {30'b0, page}, 32'd0);
        btn_next = 1'b1; step(); btn_next = 1'b0;
        chk("man_page1", {30'b0, page}, 32'd1);
        step();
        chk("man_disp1", disp_num, exp_disp(2'd1, 32'h22222222));
        btn_next = 1'b1; step(); btn_next = 1'b0;
        chk("man_page2", {30'b0, page}, 32'd2);
        btn_next = 1'b1; step(); btn_next = 1'b0;
        chk("man_page3", {30'b0, page}, 32'd3);
        btn_next = 1'b1; step(); btn_next = 1'b0;
        chk("man_wrap", {30'b0, page}, 32'd0);

        // ---- Scenario 2: auto-scan, with btn_next restarting the interval ----
        auto_en = 1'b1;
        step();
        chk("auto_entry", {30'b0, page}, 32'd0);
        for (int e = 1; e <= 16; e++) begin
            step();
            chk("auto_scan", {30'b0, page}, 32'((e / 4) % 4));
        end
        run(2);
        btn_next = 1'b1; step(); btn_next = 1'b0;
        chk("auto_btn", {30'b0, page}, 32'd1);
        run(3);
        chk("auto_restart_hold", {30'b0, page}, 32'd1);
        step();
        chk("auto_restart_adv", {30'b0, page}, 32'd2);
        auto_en = 1'b0;
        step();

        // ---- Scenario 3: single grant pins page 3, then page 1 is restored ----
        do_reset();
        btn_next = 1'b1; step(); btn_next = 1'b0;
        chk("s3_page1", {30'b0, page}, 32'd1);
        req = 4'b1000; step(); req = 4'b0000;
        chk("s3_ack",    {28'b0, ack},    32'h8);
        chk("s3_page",   {30'b0, page},   32'd3);
        chk("s3_pinned", {31'b0, pinned}, 32'd1);
        step();
        chk("s3_ack_one", {28'b0, ack}, 32'h0);
        btn_next = 1'b1; step(); btn_next = 1'b0;
        chk("s3_btn_ign", {30'b0, page}, 32'd3);
        run(5);
        chk("s3_pin_last", {31'b0, pinned}, 32'd1);
        chk("s3_page_last", {30'b0, page}, 32'd3);
        step();
        chk("s3_restore", {30'b0, page},   32'd1);
        chk("s3_unpin",   {31'b0, pinned}, 32'd0);

        // ---- Scenario 4: round-robin grants, and a grant beating btn_next ----
        do_reset();
        btn_next = 1'b1; step(); step(); btn_next = 1'b0;
        chk("s4_page2", {30'b0, page}, 32'd2);
        req = 4'b0101;
        step();
        chk("s4_g1_ack",  {28'b0, ack},  32'h1);
        chk("s4_g1_page", {30'b0, page}, 32'd0);
        run(7);
        chk("s4_g1_pin", {31'b0, pinned}, 32'd1);
        step();
        chk("s4_gap_pin",  {31'b0, pinned}, 32'd0);
        chk("s4_gap_page", {30'b0, page},   32'd2);
        chk("s4_gap_ack",  {28'b0, ack},    32'h0);
        step();
        chk("s4_g2_ack", {28'b0, ack}, 32'h4);
        run(7);
        step();
        chk("s4_gap2_pin", {31'b0, pinned}, 32'd0);
        btn_next = 1'b1; req = 4'b0111;
        step();
        btn_next = 1'b0;
        chk("s4_g3_ack",  {28'b0, ack},  32'h1);
        chk("s4_g3_page", {30'b0, page}, 32'd0);
        run(7);
        step();
        chk("s4_btn_drop", {30'b0, page}, 32'd2);
        step();
        chk("s4_g4_ack",  {28'b0, ack},  32'h2);
        chk("s4_g4_page", {30'b0, page}, 32'd1);
        req = 4'b0000;

        // ---- Scenario 5: reset in the fourth cycle of PIN ----
        do_reset();
        btn_next = 1'b1; step(); step(); btn_next = 1'b0;
        req = 4'b1000; step(); req = 4'b0000;
        run(3);
        chk("s5_pre_disp", disp_num, exp_disp(2'd3, 32'h44444444));
        #2;
        rst = 1'b1;
        #1;
        chk("s5_rst_page",   {30'b0, page},   32'd0);
        chk("s5_rst_pinned", {31'b0, pinned}, 32'd0);
        chk("s5_rst_disp",   disp_num,        32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(10);
        chk("s5_no_restore", {30'b0, page},   32'd0);
        chk("s5_unpinned",   {31'b0, pinned}, 32'd0);

        // ---- Scenario 6: display word for page 2, including the optional tag ----
        do_reset();
        src_data[95:64] = 32'h12345678;
        btn_next = 1'b1; step(); step(); btn_next = 1'b0;
        step();
        chk("s6_disp", disp_num, exp_disp(2'd2, 32'h12345678));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
